// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// seq_state_t is also driven onto the top-level dbg_state port.
package fft_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_UNLOAD = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } seq_state_t;

   localparam int FRAME_CNT_W     = 16;
   localparam int DEFAULT_TIMEOUT = 65535;

endpackage

// File: rtl/fft_seq_rdpipe.sv
// Address+valid delay line.
// It lines up each issued buffer read address with the data returned by the buffer.
module fft_seq_rdpipe #(
   parameter int DEPTH  = 1,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic [DEPTH-1:0]             valid_q;
   logic [DEPTH-1:0][ADDR_W-1:0] addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         addr_q  <= '0;
      end else begin
         valid_q[0] <= valid_i;
         addr_q[0]  <= addr_i;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// Frame sequencer between the sample buffer and the FFT core.
// It handles load, start, wait and result writeback, with timeout and overrun detection.
module fft_sequencer
   import fft_seq_pkg::*;
#(
   parameter int N_POINTS       = 512,
   parameter int ADDR_W         = $clog2(N_POINTS),
   parameter int DATA_W         = 32,
   parameter int RD_LATENCY     = 1,
   parameter int CONTINUOUS     = 1,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   buf_full,
   output logic [ADDR_W-1:0]      buf_rd_addr,
   input  logic [DATA_W-1:0]      buf_rd_data,
   output logic [ADDR_W-1:0]      buf_wr_addr,
   output logic [DATA_W-1:0]      buf_wr_data,
   output logic                   buf_wr_en,
   output logic                   fft_load,
   output logic [ADDR_W-1:0]      fft_load_addr,
   output logic [DATA_W-1:0]      fft_load_data,
   output logic                   fft_start,
   input  logic                   fft_done,
   input  logic                   fft_out_valid,
   input  logic [ADDR_W-1:0]      fft_out_addr,
   input  logic [DATA_W-1:0]      fft_out_data,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic                   overrun,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic [2:0]             dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
   localparam logic [31:0]       TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   seq_state_t             state_q, state_d;
   logic                   buf_full_q;
   logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic                   issue_done_q, issue_done_d;
   logic [ADDR_W-1:0]      str_cnt_q, str_cnt_d;
   logic [31:0]            tmo_cnt_q, tmo_cnt_d;
   logic [ADDR_W-1:0]      wr_cnt_q, wr_cnt_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]      wr_data_q, wr_data_d;
   logic                   overrun_q, overrun_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic              full_rise;
   logic              in_frame;
   logic              issue_vld;
   logic              pipe_vld;
   logic              load_vld;
   logic [ADDR_W-1:0] pipe_addr;

   assign full_rise = buf_full & ~buf_full_q;
   assign in_frame  = state_q inside {ST_LOAD, ST_START, ST_WAIT, ST_UNLOAD};
   assign issue_vld = (state_q == ST_LOAD) && !issue_done_q;
   assign load_vld  = (state_q == ST_LOAD) && pipe_vld;

   fft_seq_rdpipe #(
      .DEPTH  (RD_LATENCY),
      .ADDR_W (ADDR_W)
   ) u_rdpipe (
      .clk     (clk),
      .rst_n   (reset),
      .valid_i (issue_vld),
      .addr_i  (rd_ptr_q),
      .valid_o (pipe_vld),
      .addr_o  (pipe_addr)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (full_rise) state_d = ST_LOAD;
         ST_LOAD:   if (load_vld && str_cnt_q == LAST_IDX) state_d = ST_START;
         ST_START:  state_d = ST_WAIT;
         // A core completion in the same cycle as the timeout still counts as a completion.
         ST_WAIT: begin
            if (fft_done)                    state_d = ST_UNLOAD;
            else if (tmo_cnt_q == TMO_LAST)  state_d = ST_ERROR;
         end
         ST_UNLOAD: if (fft_out_valid && wr_cnt_q == LAST_IDX) state_d = ST_DONE;
         ST_DONE:   if (CONTINUOUS != 0 || clear) state_d = ST_IDLE;
         ST_ERROR:  if (clear) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      issue_done_d = issue_done_q;
      str_cnt_d    = str_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      overrun_d    = overrun_q;
      frame_cnt_d  = frame_cnt_q;
      case (state_q)
         ST_IDLE: begin
            rd_ptr_d     = '0;
            issue_done_d = 1'b0;
            str_cnt_d    = '0;
            wr_cnt_d     = '0;
         end
         ST_LOAD: begin
            if (rd_ptr_q != LAST_IDX) rd_ptr_d = rd_ptr_q + 1'b1;
            if (issue_vld && rd_ptr_q == LAST_IDX) issue_done_d = 1'b1;
            if (load_vld) str_cnt_d = str_cnt_q + 1'b1;
         end
         ST_START: tmo_cnt_d = '0;
         ST_WAIT:  tmo_cnt_d = tmo_cnt_q + 32'd1;
         ST_UNLOAD: begin
            if (fft_out_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = fft_out_addr;
               wr_data_d = fft_out_data;
               wr_cnt_d  = wr_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
      if (in_frame && full_rise)                overrun_d = 1'b1;
      else if (state_q == ST_IDLE && clear)     overrun_d = 1'b0;
      if (state_q == ST_UNLOAD && state_d == ST_DONE) frame_cnt_d = frame_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         buf_full_q   <= 1'b0;
         rd_ptr_q     <= '0;
         issue_done_q <= 1'b0;
         str_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         wr_cnt_q     <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         overrun_q    <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         buf_full_q   <= buf_full;
         rd_ptr_q     <= rd_ptr_d;
         issue_done_q <= issue_done_d;
         str_cnt_q    <= str_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         overrun_q    <= overrun_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign buf_rd_addr   = rd_ptr_q;
   assign buf_wr_en     = wr_en_q;
   assign buf_wr_addr   = wr_addr_q;
   assign buf_wr_data   = wr_data_q;
   assign fft_load      = load_vld;
   assign fft_load_addr = load_vld ? pipe_addr : '0;
   assign fft_load_data = load_vld ? buf_rd_data : '0;
   assign fft_start     = (state_q == ST_START);
   assign busy          = in_frame;
   assign done          = (state_q == ST_DONE);
   assign error         = (state_q == ST_ERROR);
   assign overrun       = overrun_q;
   assign frame_count   = frame_cnt_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer.
// Two instances (one-shot and continuous) share all core-side and control stimulus.
module tb_fft_sequencer;

   localparam int N   = 8;
   localparam int RDL = 2;
   localparam int AW  = 3;
   localparam int DW  = 32;
   localparam int TMO = 50;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, clear, buf_full, fft_done, fft_out_valid;
   logic [AW-1:0] fft_out_addr;
   logic [DW-1:0] fft_out_data;

   logic [AW-1:0] a_rd_addr, a_wr_addr, a_load_addr, b_rd_addr, b_wr_addr, b_load_addr;
   logic [DW-1:0] a_rd_data, a_wr_data, a_load_data, b_rd_data, b_wr_data, b_load_data;
   logic          a_wr_en, a_load, a_start, a_busy, a_done, a_error, a_overrun;
   logic          b_wr_en, b_load, b_start, b_busy, b_done, b_error, b_overrun;
   logic [15:0]   a_fc, b_fc;
   logic [2:0]    a_dbg, b_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [AW+DW-1:0] exp_q[$];

   // Buffer model: data = address + 100, returned RDL cycles after the address.
   logic [DW-1:0] a_p1, a_p2, b_p1, b_p2;
   always @(posedge clk) begin
      a_p1 <= DW'(a_rd_addr) + 32'd100;
      a_p2 <= a_p1;
      b_p1 <= DW'(b_rd_addr) + 32'd100;
      b_p2 <= b_p1;
   end
   assign a_rd_data = a_p2;
   assign b_rd_data = b_p2;

   fft_sequencer #(.N_POINTS(N), .DATA_W(DW), .RD_LATENCY(RDL), .CONTINUOUS(0), .TIMEOUT_CYCLES(TMO)) dut_os (
      .clk(clk), .reset(reset), .clear(clear), .buf_full(buf_full),
      .buf_rd_addr(a_rd_addr), .buf_rd_data(a_rd_data),
      .buf_wr_addr(a_wr_addr), .buf_wr_data(a_wr_data), .buf_wr_en(a_wr_en),
      .fft_load(a_load), .fft_load_addr(a_load_addr), .fft_load_data(a_load_data),
      .fft_start(a_start), .fft_done(fft_done),
      .fft_out_valid(fft_out_valid), .fft_out_addr(fft_out_addr), .fft_out_data(fft_out_data),
      .busy(a_busy), .done(a_done), .error(a_error), .overrun(a_overrun),
      .frame_count(a_fc), .dbg_state(a_dbg)
   );

   fft_sequencer #(.N_POINTS(N), .DATA_W(DW), .RD_LATENCY(RDL), .CONTINUOUS(1), .TIMEOUT_CYCLES(TMO)) dut_ct (
      .clk(clk), .reset(reset), .clear(clear), .buf_full(buf_full),
      .buf_rd_addr(b_rd_addr), .buf_rd_data(b_rd_data),
      .buf_wr_addr(b_wr_addr), .buf_wr_data(b_wr_data), .buf_wr_en(b_wr_en),
      .fft_load(b_load), .fft_load_addr(b_load_addr), .fft_load_data(b_load_data),
      .fft_start(b_start), .fft_done(fft_done),
      .fft_out_valid(fft_out_valid), .fft_out_addr(fft_out_addr), .fft_out_data(fft_out_data),
      .busy(b_busy), .done(b_done), .error(b_error), .overrun(b_overrun),
      .frame_count(b_fc), .dbg_state(b_dbg)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // done_delay < 0 runs a frame whose core never finishes.
   // abort_after > 0 resets mid-unload after that many writes.
   task automatic run_frame(input int done_delay, input logic ovr, input int abort_after,
                            input logic [15:0] exp_fc);
      int ld_idx, start_n, nstart, err_n, nwr, b;
      logic aborted;
      logic [AW+DW-1:0] e;
      ld_idx = 0; start_n = 0; nstart = 0; err_n = 0; nwr = 0; b = 0; aborted = 1'b0;

      @(negedge clk);
      buf_full = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 3) buf_full = 1'b0;
         if (a_load) begin
            check("load_addr", a_load_addr, ld_idx);
            check("load_data", a_load_data, ld_idx + 100);
            ld_idx++;
         end
         if (a_start) begin
            nstart++;
            if (start_n == 0) start_n = k;
         end
         if (start_n != 0 && k == start_n + 2) break;
      end
      check("load_count", ld_idx, N);
      check("start_pulses", nstart, 1);
      // LOAD is entered on the negedge numbered 1; the phase lasts N+RDL cycles.
      check("start_cycle", start_n, 1 + N + RDL);

      if (done_delay < 0) begin
         for (int k = start_n + 3; k <= start_n + 80; k++) begin
            @(negedge clk);
            if (a_error) begin
               err_n = k;
               break;
            end
         end
         check("timeout_cycle", err_n - start_n, TMO + 1);
         check("timeout_done", a_done, 0);
         check("timeout_busy", a_busy, 0);
         check("timeout_fc", a_fc, exp_fc);
         check("timeout_b_error", b_error, 1);
         repeat (2) @(negedge clk);
         check("error_hold", a_error, 1);
         clear = 1'b1;
         @(negedge clk);
         clear = 1'b0;
         @(negedge clk);
         check("error_clear_a", a_error, 0);
         check("error_clear_b", b_error, 0);
         check("error_fc", a_fc, exp_fc);
         return;
      end

      for (int j = 0; j < done_delay; j++) begin
         @(negedge clk);
         if (ovr && j == 3) buf_full = 1'b1;
         if (j == 5) buf_full = 1'b0;
      end
      check("overrun_in_wait", a_overrun, ovr);
      fft_done = 1'b1;

      for (int s = 0; s < 10; s++) begin
         @(negedge clk);
         fft_done = 1'b0;
         if (aborted) begin
            reset = 1'b1;
            check("wr_after_reset", a_wr_en, 0);
         end else if (a_wr_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '1;
            check("wr_pair", {a_wr_addr, a_wr_data}, e);
            nwr++;
            if (nwr == abort_after) begin
               reset = 1'b0;
               #1;
               check("rst_async_wr", {a_wr_en, a_wr_addr, a_wr_data}, 0);
               check("rst_async_flags", {a_busy, a_done, a_error, a_overrun, a_load, a_start}, 0);
               check("rst_async_fc", a_fc, 0);
               aborted = 1'b1;
               exp_q.delete();
            end
         end
         if (b < N && s != 3) begin
            fft_out_valid = 1'b1;
            fft_out_addr  = AW'(N - 1 - b);
            fft_out_data  = 32'hA0 + DW'(b);
            if (!aborted) exp_q.push_back({fft_out_addr, fft_out_data});
            b++;
         end else begin
            fft_out_valid = 1'b0;
         end
      end

      if (aborted) begin
         check("abort_done", a_done, 0);
         check("abort_busy", a_busy, 0);
         check("abort_fc", a_fc, 0);
         return;
      end
      check("wr_count", nwr, N);
      check("wr_left", exp_q.size(), 0);
      check("a_done_entry", a_done, 1);
      check("b_done_entry", b_done, 1);
      check("a_fc", a_fc, exp_fc);
      check("b_fc", b_fc, exp_fc);
      @(negedge clk);
      check("b_done_pulse", b_done, 0);
      check("a_done_hold", a_done, 1);
      repeat (3) @(negedge clk);
      check("a_done_hold_late", a_done, 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      check("a_done_clear", a_done, 0);
      check("a_idle_busy", a_busy, 0);
      if (ovr) begin
         clear = 1'b1;
         @(negedge clk);
         clear = 1'b0;
         @(negedge clk);
      end
      check("a_overrun_end", a_overrun, 0);
      check("b_overrun_end", b_overrun, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; clear = 1'b0; buf_full = 1'b0; fft_done = 1'b0;
      fft_out_valid = 1'b0; fft_out_addr = '0; fft_out_data = '0;
      repeat (2) @(negedge clk);
      check("rst_state", a_dbg, 0);
      check("rst_flags_a", {a_busy, a_done, a_error, a_overrun, a_load, a_start, a_wr_en}, 0);
      check("rst_flags_b", {b_busy, b_done, b_error, b_overrun, b_load, b_start, b_wr_en}, 0);
      check("rst_fc", a_fc, 0);
      check("rst_wr", {a_wr_addr, a_wr_data, a_rd_addr}, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", a_busy, 0);

      run_frame(20, 1'b0, 0, 16'd1);
      run_frame(20, 1'b0, 0, 16'd2);
      run_frame(20, 1'b0, 0, 16'd3);
      run_frame(20, 1'b1, 0, 16'd4);
      run_frame(-1, 1'b0, 0, 16'd4);
      run_frame(20, 1'b0, 4, 16'd0);
      repeat (2) @(negedge clk);
      run_frame(20, 1'b0, 0, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
